data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Two-port arbiter that shares the single data RAM between the CPU load/store path and a debug/loader port. It sits between the CPU datapath's `alu_out`/`regfile_read_data2`/`MemRead`/`MemWrite` signals, a debug master, and the RAM. It issues at most one RAM access per cycle and holds off a losing requester with a stall. Read responses are tracked through a tag pipeline so each read returns to the port that issued it.

## Interface
- ADDR_W, 32, address width, passed unchanged to RAM
- DATA_W, 32, data width
- RD_LAT, 1, RAM read latency in cycles (legal 1..4)
- CPU_PRIO, 0, 0 = round-robin on conflict; 1 = CPU always wins
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  store data
- cpu_gnt  out  1  access issued to RAM this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt (freezes PC/pipeline)
- cpu_rvalid  out  1  load data valid
- cpu_rdata  out  DATA_W  load data, 0 when cpu_rvalid=0
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug port, same meaning as cpu_*
- dbg_gnt, dbg_rvalid  out  1  as cpu_*
- dbg_rdata  out  DATA_W  as cpu_rdata
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable (valid only with ram_en)
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after ram_en with ram_we=0

## Operation
- Winner per cycle:
  - only one requester asserts req → it wins.
  - both assert req, CPU_PRIO=1 → CPU wins.
  - both assert req, CPU_PRIO=0 → the port that was not `last_win` wins.
- `last_win` register: updated only on a conflict cycle to the conflict winner. Non-conflict grants leave it unchanged.
- Winner's gnt=1, loser's gnt=0; ram_en=1, and ram_we/addr/wdata are muxed from the winner.
- No req → ram_en=0, ram_we=0, ram_addr/ram_wdata=0.
- Grant is combinational from the current req and `last_win`. Requester contract: req, we, addr and wdata stay stable until gnt. Dropping req before gnt is legal and cancels the request.
- Writes complete at the grant edge; no response is returned.
- Reads push the tag {valid=1, port} into an RD_LAT-deep shift register; a write or idle cycle pushes valid=0.
  - Tag at the pipeline output valid → the matching rvalid=1 and that port's rdata=ram_rdata.
  - The other port's rdata=0.
- Throughput: one access per cycle, back-to-back, with no bubbles. Reads and writes may interleave freely. Read data reflects any write granted in an earlier cycle.

## Timing
- Reset values: last_win=DBG (so CPU wins the first conflict); tag pipeline cleared.
- During and directly after reset: all gnt/rvalid=0, all rdata=0, ram_en=0, ram_we=0.
- While rst=1, gnt is forced to 0 regardless of req.
- Read granted in cycle N → that port's rvalid=1 in cycle N+RD_LAT, for exactly one cycle.
- Reset mid-operation: all in-flight reads are discarded and no rvalid follows for them. The first grant after reset is possible in the first cycle with rst=0.
- Under sustained conflict with CPU_PRIO=0, grants alternate CPU, DBG, CPU, …; neither port waits more than 1 cycle.
- Under CPU_PRIO=1, a continuous cpu_req starves dbg; this is intended.
- cpu_stall is combinational, the same cycle as cpu_req.
- Same-port consecutive reads return in issue order, one per cycle.

## Test plan
- Reset then idle, RD_LAT=1: hold rst 3 cycles with both req=1 → no gnt, no ram_en during reset. First conflict after release → cpu_gnt=1.
- CPU load, RD_LAT=2: RAM word 0x40 preloaded 0xDEADBEEF; cpu_req load 0x40 in cycle 5 → cpu_gnt in 5, cpu_rvalid=1 with cpu_rdata=0xDEADBEEF in cycle 7 only; dbg_rvalid stays 0.
- Conflict, round-robin: both ports request loads for 4 cycles, CPU_PRIO=0 → grants CPU, DBG, CPU, DBG. cpu_stall=1 in cycles 2 and 4. Responses are routed to the matching ports.
- Store then load: dbg store 0x12345678 to 0x80 in cycle N, then cpu load 0x80 in N+1 → cpu_rdata=0x12345678 at N+1+RD_LAT.
- Reset mid-read, RD_LAT=3: read granted in cycle N, rst=1 in cycle N+1 → no rvalid in N+3.
- CPU_PRIO=1: continuous cpu_req and dbg_req for 10 cycles → dbg_gnt=0 throughout. After cpu_req drops, dbg_gnt=1 in the same cycle.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one data RAM between the CPU load/store path and a debug port
module data_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter bit CPU_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic {PORT_CPU, PORT_DBG} port_e;
  port_e             last_win_q, last_win_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d, tag_dbg_q, tag_dbg_d;
  logic              conflict, cpu_win, dbg_win, tag_out;
  // Pick the winner, mux it onto the RAM, and push the read tag for this cycle
  always_comb begin
    conflict   = cpu_req & dbg_req;
    cpu_win    = ~rst & cpu_req & (~dbg_req | CPU_PRIO | (last_win_q == PORT_DBG));
    dbg_win    = ~rst & dbg_req & ~cpu_win;
    ram_en     = cpu_win | dbg_win;
    ram_we     = cpu_win ? cpu_we : dbg_win & dbg_we;
    ram_addr   = cpu_win ? cpu_addr : dbg_win ? dbg_addr : '0;
    ram_wdata  = cpu_win ? cpu_wdata : dbg_win ? dbg_wdata : '0;
    last_win_d = (conflict & ~rst) ? (cpu_win ? PORT_CPU : PORT_DBG) : last_win_q;
    tag_vld_d  = RD_LAT'({tag_vld_q, ram_en & ~ram_we});
    tag_dbg_d  = RD_LAT'({tag_dbg_q, dbg_win});
    tag_out    = ~rst & tag_vld_q[RD_LAT-1];
    cpu_gnt    = cpu_win;
    dbg_gnt    = dbg_win;
    cpu_stall  = cpu_req & ~cpu_win;
    cpu_rvalid = tag_out & ~tag_dbg_q[RD_LAT-1];
    dbg_rvalid = tag_out & tag_dbg_q[RD_LAT-1];
    cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
    dbg_rdata  = dbg_rvalid ? ram_rdata : '0;
  end
  // Reset discards in-flight reads and hands the first conflict to the CPU
  always_ff @(posedge clk) begin
    if (rst) begin
      last_win_q <= PORT_DBG;
      tag_vld_q  <= '0;
      tag_dbg_q  <= '0;
    end else begin
      last_win_q <= last_win_d;
      tag_vld_q  <= tag_vld_d;
      tag_dbg_q  <= tag_dbg_d;
    end
  end
endmodule
